// File: rtl/seq_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : seq_chunk_adder
// Brief    : Multi-cycle adder/subtractor that adds CHUNK bits per clock,
//            LSB slice first, with a registered carry between slices and a
//            valid/ready handshake on both sides.
//            Optional feature macro: ADDER_OVF_EN (adds signed-overflow port
//            ovf; absent by default).
// Revision : 1.0 - initial release
// ============================================================================
module seq_chunk_adder #(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4   // WIDTH must be a multiple of CHUNK, CHUNK >= 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
`ifdef ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NCH  = WIDTH / CHUNK;
  localparam int IDXW = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;       // operand A, shifted right one slice per cycle
  logic [WIDTH-1:0] b_q, b_d;       // operand B (already inverted for subtract)
  logic [WIDTH-1:0] part_q, part_d; // partial result, filled from the top down
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [IDXW-1:0]  idx_q, idx_d;

  logic [CHUNK-1:0] a_slice;
  logic [CHUNK-1:0] b_slice;
  logic [CHUNK:0]   slice_res;
  logic [WIDTH-1:0] part_next;

`ifdef ADDER_OVF_EN
  logic             ovf_q, ovf_d;
  logic             msb_carry_in;
`endif

  // Slice datapath: the current slice always sits in the low bits of the
  // operand registers, and finished slices enter the partial result at the top
  // so that after NCH shifts every slice has landed in its final position.
  always_comb begin
    a_slice   = a_q[CHUNK-1:0];
    b_slice   = b_q[CHUNK-1:0];
    slice_res = {1'b0, a_slice} + {1'b0, b_slice} + {{CHUNK{1'b0}}, carry_q};
    part_next = (part_q >> CHUNK) | (WIDTH'(slice_res[CHUNK-1:0]) << (WIDTH - CHUNK));
`ifdef ADDER_OVF_EN
    // On the last slice the top bit of the slice is the word MSB; the carry
    // into it is recovered from the sum bit and the two operand bits.
    msb_carry_in = a_slice[CHUNK-1] ^ b_slice[CHUNK-1] ^ slice_res[CHUNK-1];
`endif
  end

  // Next-state and register-update logic for the IDLE -> CALC -> DONE sequence.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    part_d  = part_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    idx_d   = idx_q;
`ifdef ADDER_OVF_EN
    ovf_d   = ovf_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready) begin
          a_d     = a;
          // Subtract is a + ~b + 1; the +1 rides in as the initial carry.
          b_d     = sub ? ~b : b;
          carry_d = sub ? 1'b1 : cin;
          part_d  = '0;
          idx_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        a_d     = a_q >> CHUNK;
        b_d     = b_q >> CHUNK;
        part_d  = part_next;
        carry_d = slice_res[CHUNK];
        idx_d   = idx_q + 1'b1;
        if (idx_q == LAST_IDX) begin
          // Result registers only change here, so they stay put in DONE and IDLE.
          sum_d   = part_next;
          cout_d  = slice_res[CHUNK];
`ifdef ADDER_OVF_EN
          ovf_d   = msb_carry_in ^ slice_res[CHUNK];
`endif
          idx_d   = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      part_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      idx_q   <= '0;
`ifdef ADDER_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      part_q  <= part_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      idx_q   <= idx_d;
`ifdef ADDER_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  // Handshake and status outputs decoded from the state register.
  always_comb begin
    in_ready  = (state_q == IDLE) && rst_n;
    out_valid = (state_q == DONE);
    busy      = (state_q != IDLE);
    sum       = sum_q;
    cout      = cout_q;
`ifdef ADDER_OVF_EN
    ovf       = ovf_q;
`endif
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_chunk_adder.sv
`default_nettype none
// ============================================================================
// Module   : tb_seq_chunk_adder
// Brief    : Scoreboard bench for seq_chunk_adder (WIDTH=16, CHUNK=4).
//            Directed operands with hand-computed results are queued on issue;
//            a negedge monitor pops and compares on every output handshake and
//            checks result latency.
// Revision : 1.0 - initial release
// ============================================================================
module tb_seq_chunk_adder;

  localparam int WIDTH = 16;
  localparam int CHUNK = 4;
  localparam int NCH   = WIDTH / CHUNK;

  typedef struct packed {
    logic [WIDTH-1:0] s;
    logic             c;
    logic             v;
  } exp_t;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             in_valid  = 1'b0;
  logic             cin       = 1'b0;
  logic             sub       = 1'b0;
  logic             out_ready = 1'b1;
  logic [WIDTH-1:0] a         = '0;
  logic [WIDTH-1:0] b         = '0;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             busy;
`ifdef ADDER_OVF_EN
  logic             ovf;
`endif

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  int   acc_cyc  = 0;
  bit   pending  = 1'b0;
  logic ov_prev  = 1'b0;

  always #5 clk = ~clk;

  seq_chunk_adder #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
`ifdef ADDER_OVF_EN
    ,
    .ovf       (ovf)
`endif
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: spots accepts, checks result latency and pops the scoreboard.
  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (rst_n && in_valid && in_ready) begin
      acc_cyc = cyc;
      pending = 1'b1;
    end
    if (out_valid === 1'b1 && ov_prev !== 1'b1) begin
      check("result_has_accept", 32'(pending), 32'd1);
      if (pending) check("latency", 32'(cyc - acc_cyc), 32'(NCH + 1));
      pending = 1'b0;
    end
    if (out_valid === 1'b1 && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        check("sum", 32'(sum), 32'(e.s));
        check("cout", 32'(cout), 32'(e.c));
`ifdef ADDER_OVF_EN
        check("ovf", 32'(ovf), 32'(e.v));
`endif
      end
    end
    ov_prev = out_valid;
  end

  task automatic send(input logic [WIDTH-1:0] ta, input logic [WIDTH-1:0] tbv,
                      input logic tc, input logic ts,
                      input logic [WIDTH-1:0] es, input logic ec, input logic ev,
                      input bit push);
    bit got = 1'b0;
    @(posedge clk); #1;
    a = ta; b = tbv; cin = tc; sub = ts; in_valid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (in_ready) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    if (push) exp_q.push_back({es, ec, ev});
    @(posedge clk); #1;
    // Garbage on the inputs while busy must not disturb the operation.
    in_valid = 1'b0; a = 16'hDEAD; b = 16'hBEEF; cin = 1'b1; sub = 1'b1;
  endtask

  task automatic wait_drain();
    bit ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && out_valid === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("drain_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    bit seen;
    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("in_ready_after_rst", 32'(in_ready), 32'd1);

    // Plain add, full carry chain, subtract with borrow, signed overflow
    send(16'h1234, 16'h0FED, 1'b0, 1'b0, 16'h2221, 1'b0, 1'b0, 1'b1); wait_drain();
    send(16'hFFFF, 16'h0001, 1'b1, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b1); wait_drain();
    send(16'h0003, 16'h0005, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b1); wait_drain();
    send(16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b1); wait_drain();
    check("idle_sum_held", 32'(sum), 32'h8000);
    check("idle_busy", 32'(busy), 32'd0);

    // Backpressure: result must hold and new operands must be refused
    out_ready = 1'b0;
    send(16'h00FF, 16'h0F01, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 1'b1);
    seen = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (out_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!seen) check("bp_valid_timeout", 32'd0, 32'd1);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      in_valid = ~in_valid; a = 16'hAAAA + 16'(i); b = 16'h5555;
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 32'd0);
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_busy", 32'(busy), 32'd1);
      check("bp_sum_held", 32'(sum), 32'h1000);
    end
    @(posedge clk); #1;
    in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    @(negedge clk);
    check("bp_out_valid_drop", 32'(out_valid), 32'd0);
    check("bp_in_ready_after", 32'(in_ready), 32'd1);
    check("bp_sum_kept", 32'(sum), 32'h1000);

    // Reset during the second slice: the operation must vanish
    send(16'h1111, 16'h2222, 1'b0, 1'b0, 16'h3333, 1'b0, 1'b0, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_busy", 32'(busy), 32'd0);
    check("rst_mid_in_ready", 32'(in_ready), 32'd1);
    check("rst_mid_sum", 32'(sum), 32'd0);
    repeat (NCH + 2) begin
      @(negedge clk);
      check("rst_mid_no_valid", 32'(out_valid), 32'd0);
    end

    // Operations after the aborted one
    send(16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1); wait_drain();
    send(16'h0005, 16'h0003, 1'b0, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b1); wait_drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
